mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port memory_unit between two requesters: instruction fetch (IF) and data load/store (DM).
- Sits between the core's PC/fetch logic plus LSU and a unified memory.
- Serialises accesses through a 4-state FSM and waits a fixed memory latency.
- Returns read data with a one-cycle acknowledge pulse to the winning requester.

Parameters:
- ADDRSIZE, 8, memory address width in bits.
- WORDSIZE, 64, data width of memory and both ports.
- MEM_LAT, 1, cycles between the strobe-sampling edge and mem_q being valid. Legal range 0..7.

Ports:
- clk  in  1  clock; everything is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF request; held until if_ack.
- if_addr  in  ADDRSIZE  IF address; stable while if_req is high.
- if_ack  out  1  one-cycle completion pulse to IF.
- if_rdata  out  WORDSIZE  IF read data; valid when if_ack=1.
- dm_req  in  1  DM request; held until dm_ack.
- dm_we  in  1  DM access type: 1 = write, 0 = read.
- dm_addr  in  ADDRSIZE  DM address.
- dm_wdata  in  WORDSIZE  DM write data.
- dm_ack  out  1  one-cycle completion pulse to DM.
- dm_rdata  out  WORDSIZE  DM read data; valid on dm_ack for reads, 0 for writes.
- mem_rden  out  1  memory read strobe.
- mem_wren  out  1  memory write strobe.
- mem_addr  out  ADDRSIZE  memory address.
- mem_d  out  WORDSIZE  memory write data.
- mem_q  in  WORDSIZE  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset state: all outputs 0, state IDLE, wait counter 0, last-grant pointer = IF.
- rst high on any edge aborts an in-flight transaction: no ack is issued and the strobes drop in the next cycle.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - At edge E0 with any req high: latch winner, address, write data and direction; go to ISSUE.
  - With no req high: stay in IDLE.
- ISSUE:
  - Lasts exactly one cycle.
  - All mem_* outputs are registered: mem_rden or mem_wren = 1 with the latched addr/data.
  - IF requests are always reads.
  - Next state is WAIT if MEM_LAT > 0, else RESP with mem_q captured at this edge.
- WAIT:
  - Strobes are 0 and mem_addr is held.
  - Counter loads MEM_LAT-1 on entry and decrements each cycle.
  - At the edge where the counter equals 0: capture mem_q (reads only) and go to RESP.
- RESP:
  - The winner's ack = 1 for exactly one cycle, with rdata registered.
  - The loser's ack = 0 and its rdata is held at its previous value.
  - Next state is always IDLE; reqs are ignored during RESP.
- Latency: ack is high in the cycle following edge E0+MEM_LAT+1. Sustained throughput is one access per MEM_LAT+3 cycles.
- A req dropped before its grant edge is not served. Once granted, the transaction completes and acks even if req has already fallen.
- A req still high in the cycle after its ack is treated as a new request.
- Simultaneous if_req and dm_req in IDLE are resolved per the Optional Feature; the loser waits and is re-arbitrated on the next IDLE.
- Addresses pass through unmodified, with no wrap or alignment checks.
- Writes never drive mem_rden; write acks return rdata = 0.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On a conflict, grant the requester not recorded in the last-grant pointer.
  - The pointer updates on every grant.
  - The reset value IF means DM wins the first conflict.
- Undefined: fixed priority, DM always beats IF. The pointer is not implemented; IF can starve under back-to-back DM traffic.

Decomposition:
- Shared package riscv_mem_pkg:
  - state encoding typedef (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - requester ID constants REQ_IF=0, REQ_DM=1;
  - default MEM_LAT.
- One combinational sub-module, mem_arb_pick, natural home of the MEM_ARB_RR_EN selection.
  - Inputs: if_req, dm_req, last_gnt.
  - Outputs: gnt_valid, gnt_id.

Test Plan:
- Reset, then a single IF read: preload mem[0x10]=0xDEADBEEF, if_addr=0x10, MEM_LAT=1 → if_ack exactly 3 cycles after the request edge, if_rdata=0xDEADBEEF, one-cycle mem_rden.
- DM write then read: write 0x1122334455667788 to 0x20, then read 0x20 → write ack with dm_rdata=0, read returns 0x1122334455667788, mem_wren high exactly one cycle.
- Simultaneous requests, held high:
  - RR_EN defined → grant order DM, IF, DM, IF.
  - Undefined, with dm_req kept high → four DM acks and no IF ack.
- Reset mid-transaction: assert rst during WAIT → no ack ever, busy=0 and strobes 0 from the next cycle, and a following request completes normally.
- MEM_LAT sweep 0, 3, 7 → ack latency of 1, 4, 8 cycles after the ISSUE cycle, and busy low only in IDLE.
- Request dropped after grant: if_req drops the cycle after E0 → transaction completes and if_ack still pulses once.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Contents: FSM state encoding, requester IDs, default memory latency and the
// width of the latency wait counter.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam int unsigned MEM_LAT_DEFAULT = 1;

    // Wide enough for the largest legal MEM_LAT (7).
    localparam int unsigned LAT_CNT_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between instruction fetch and data requests.
// Macro: MEM_ARB_RR_EN selects round-robin on conflicts; otherwise DM always wins.
// Ports:
//   if_req, dm_req  pending requests
//   last_gnt        requester granted most recently (only used with round-robin)
//   gnt_valid       at least one request is pending
//   gnt_id          winning requester (REQ_IF / REQ_DM)
module mem_arb_pick
    import riscv_mem_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_id
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        gnt_valid = if_req | dm_req;
        gnt_id    = REQ_IF;
        if (if_req && dm_req) begin
            // On a conflict favour whoever was not granted last time.
            gnt_id = (last_gnt == REQ_IF) ? REQ_DM : REQ_IF;
        end else if (dm_req) begin
            gnt_id = REQ_DM;
        end
    end
`else
    // Fixed priority has no use for the grant history.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        gnt_valid = if_req | dm_req;
        gnt_id    = REQ_IF;
        if (dm_req) begin
            gnt_id = REQ_DM;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and
// data load/store (DM). Accesses are serialised IDLE -> ISSUE -> WAIT -> RESP,
// with a fixed memory latency and a one-cycle ack to the winner.
// Macro: MEM_ARB_RR_EN enables round-robin arbitration (default: DM priority).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              IF read request
//   if_ack/if_rdata             IF completion pulse and read data
//   dm_req/dm_we/dm_addr/dm_wdata  DM request
//   dm_ack/dm_rdata             DM completion pulse and read data (0 on writes)
//   mem_rden/mem_wren/mem_addr/mem_d/mem_q  memory interface
//   busy                        high whenever the FSM is not in IDLE
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDRSIZE = 8,
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned MEM_LAT  = MEM_LAT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDRSIZE-1:0] if_addr,
    output logic                if_ack,
    output logic [WORDSIZE-1:0] if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDRSIZE-1:0] dm_addr,
    input  logic [WORDSIZE-1:0] dm_wdata,
    output logic                dm_ack,
    output logic [WORDSIZE-1:0] dm_rdata,
    output logic                mem_rden,
    output logic                mem_wren,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_d,
    input  logic [WORDSIZE-1:0] mem_q,
    output logic                busy
);

    localparam int unsigned CNT_LOAD = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;

    arb_state_e           state;
    arb_state_e           state_nxt;
    logic [LAT_CNT_W-1:0] cnt;
    logic                 win_id;
    logic                 win_we;
    logic                 last_gnt;
    logic                 gnt_valid;
    logic                 gnt_id;
    logic                 grant;
    logic                 capture;
    logic                 rden_nxt;
    logic                 wren_nxt;
    logic                 if_ack_nxt;
    logic                 dm_ack_nxt;

    mem_arb_pick u_pick (
        .if_req    (if_req),
        .dm_req    (dm_req),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = (MEM_LAT == 0) ? RESP : WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        grant      = (state == IDLE) && gnt_valid;
        capture    = ((state == ISSUE) && (MEM_LAT == 0)) ||
                     ((state == WAIT) && (cnt == '0));
        rden_nxt   = grant && !((gnt_id == REQ_DM) && dm_we);
        wren_nxt   = grant && (gnt_id == REQ_DM) && dm_we;
        if_ack_nxt = capture && (win_id == REQ_IF);
        dm_ack_nxt = capture && (win_id == REQ_DM);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            win_id   <= REQ_IF;
            win_we   <= 1'b0;
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
            mem_addr <= '0;
            mem_d    <= '0;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
            busy     <= 1'b0;
        end else begin
            mem_rden <= rden_nxt;
            mem_wren <= wren_nxt;
            if_ack   <= if_ack_nxt;
            dm_ack   <= dm_ack_nxt;
            busy     <= (state_nxt != IDLE);

            if (grant) begin
                win_id   <= gnt_id;
                win_we   <= (gnt_id == REQ_DM) && dm_we;
                mem_addr <= (gnt_id == REQ_DM) ? dm_addr : if_addr;
                mem_d    <= ((gnt_id == REQ_DM) && dm_we) ? dm_wdata : '0;
            end

            // Counter is loaded leaving ISSUE and reaches zero on the capture edge.
            if (state == ISSUE) begin
                cnt <= LAT_CNT_W'(CNT_LOAD);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - LAT_CNT_W'(1);
            end

            if (if_ack_nxt) begin
                if_rdata <= mem_q;
            end
            if (dm_ack_nxt) begin
                dm_rdata <= win_we ? '0 : mem_q;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Grant history for round-robin; reset value IF lets DM win the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= REQ_IF;
        end else if (grant) begin
            last_gnt <= gnt_id;
        end
    end
`else
    assign last_gnt = REQ_IF;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected acks and memory
// strobes, plus three extra instances sweeping MEM_LAT over 0, 3 and 7.
module tb_mem_arbiter;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 64;
    localparam int unsigned LAT = 1;
    localparam int unsigned SW_LAT [3] = '{0, 3, 7};

    logic          clk = 1'b0;
    logic          rst;
    int            cyc = 0;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          mem_rden;
    logic          mem_wren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q;
    logic          busy;

    logic [DW-1:0] mem [256];

    logic [2:0]         sw_if_req;
    logic [2:0][AW-1:0] sw_if_addr;
    logic [2:0]         sw_if_ack;
    logic [2:0][DW-1:0] sw_if_rdata;
    logic [2:0]         sw_dm_ack;
    logic [2:0][DW-1:0] sw_dm_rdata;
    logic [2:0]         sw_rden;
    logic [2:0]         sw_wren;
    logic [2:0][AW-1:0] sw_addr;
    logic [2:0][DW-1:0] sw_d;
    logic [2:0][DW-1:0] sw_q;
    logic [2:0]         sw_busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit            is_dm;
        logic [DW-1:0] data;
        int            cyc;
    } ack_exp_t;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } str_exp_t;

    ack_exp_t ack_exp_q[$];
    str_exp_t str_exp_q[$];
    ack_exp_t ae;
    str_exp_t se;
    logic     prev_strobe = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.ADDRSIZE(AW), .WORDSIZE(DW), .MEM_LAT(LAT)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .mem_rden (mem_rden),
        .mem_wren (mem_wren),
        .mem_addr (mem_addr),
        .mem_d    (mem_d),
        .mem_q    (mem_q),
        .busy     (busy)
    );

    // One-cycle-latency memory: data appears the cycle after a sampled read strobe.
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_d;
        mem_q <= mem_rden ? mem[mem_addr] : 64'hBADC_0FFE_E0DD_F00D;
    end

    function automatic logic [DW-1:0] sw_pat(input logic [AW-1:0] a);
        return 64'hC3C3_0000_0000_0000 | 64'(a);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_sw
        mem_arbiter #(.ADDRSIZE(AW), .WORDSIZE(DW), .MEM_LAT(SW_LAT[g])) u_sw (
            .clk      (clk),
            .rst      (rst),
            .if_req   (sw_if_req[g]),
            .if_addr  (sw_if_addr[g]),
            .if_ack   (sw_if_ack[g]),
            .if_rdata (sw_if_rdata[g]),
            .dm_req   (1'b0),
            .dm_we    (1'b0),
            .dm_addr  (8'h00),
            .dm_wdata (64'h0),
            .dm_ack   (sw_dm_ack[g]),
            .dm_rdata (sw_dm_rdata[g]),
            .mem_rden (sw_rden[g]),
            .mem_wren (sw_wren[g]),
            .mem_addr (sw_addr[g]),
            .mem_d    (sw_d[g]),
            .mem_q    (sw_q[g]),
            .busy     (sw_busy[g])
        );
        // Address-held memory: data is valid as soon as the address is latched.
        assign sw_q[g] = sw_pat(sw_addr[g]);
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor for the main instance
    always @(negedge clk) begin
        if (if_ack || dm_ack) begin
            if (ack_exp_q.size() == 0) begin
                check("spurious_ack", 64'({dm_ack, if_ack}), 64'(0));
            end else begin
                ae = ack_exp_q.pop_front();
                check("ack_who", 64'({dm_ack, if_ack}), ae.is_dm ? 64'(2) : 64'(1));
                check("ack_rdata", ae.is_dm ? dm_rdata : if_rdata, ae.data);
                check("ack_cycle", 64'(cyc), 64'(ae.cyc));
            end
        end
        if (mem_rden || mem_wren) begin
            check("strobe_1cyc", 64'(prev_strobe), 64'(0));
            if (str_exp_q.size() == 0) begin
                check("spurious_strobe", 64'({mem_wren, mem_rden}), 64'(0));
            end else begin
                se = str_exp_q.pop_front();
                check("strobe_kind", 64'({mem_wren, mem_rden}), se.wr ? 64'(2) : 64'(1));
                check("strobe_addr", 64'(mem_addr), 64'(se.addr));
                if (se.wr) check("strobe_wdata", mem_d, se.data);
            end
        end
        prev_strobe <= mem_rden | mem_wren;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic access(input bit is_dm, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                          input bit drop_early);
        int n = 0;
        bit got = 0;
        wait_idle();
        ack_exp_q.push_back('{is_dm: is_dm, data: (is_dm && we) ? 64'h0 : exp_rd,
                              cyc: cyc + int'(LAT) + 2});
        str_exp_q.push_back('{wr: is_dm && we, addr: a, data: wd});
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        @(negedge clk);
        if (drop_early) begin
            if_req = 1'b0; dm_req = 1'b0;
        end
        while (!got && n < 20) begin
            if (is_dm ? dm_ack : if_ack) got = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!got) check("ack_timeout", 64'(0), 64'(1));
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    task automatic sweep_one(input int i, input int lat);
        logic [AW-1:0] a;
        a = AW'(8'h30 + i);
        @(negedge clk);
        check("sw_busy_idle", 64'(sw_busy[i]), 64'(0));
        sw_if_req[i]  = 1'b1;
        sw_if_addr[i] = a;
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            check($sformatf("sw%0d_busy", lat), 64'(sw_busy[i]), 64'(k <= lat + 2));
            check($sformatf("sw%0d_ack", lat), 64'(sw_if_ack[i]), 64'(k == lat + 2));
            if (k == lat + 2) begin
                check($sformatf("sw%0d_rdata", lat), sw_if_rdata[i], sw_pat(a));
                sw_if_req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        int acks;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 64'(i) * 64'h0101_0101;
        mem[8'h10] = 64'hDEAD_BEEF;
        mem[8'h40] = 64'h4040_4040_4040_4040;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        sw_if_req = '0; sw_if_addr = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", 64'(busy), 64'(0));
        check("rst_if_ack", 64'(if_ack), 64'(0));
        check("rst_dm_ack", 64'(dm_ack), 64'(0));
        check("rst_rden", 64'(mem_rden), 64'(0));
        check("rst_wren", 64'(mem_wren), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_d", mem_d, 64'(0));
        check("rst_if_rdata", if_rdata, 64'(0));
        check("rst_dm_rdata", dm_rdata, 64'(0));
        rst = 1'b0;

        // Single IF read
        access(1'b0, 1'b0, 8'h10, 64'h0, 64'hDEAD_BEEF, 1'b0);

        // DM write then read back
        access(1'b1, 1'b1, 8'h20, 64'h1122_3344_5566_7788, 64'h0, 1'b0);
        wait_idle();
        check("mem_written", mem[8'h20], 64'h1122_3344_5566_7788);
        access(1'b1, 1'b0, 8'h20, 64'h0, 64'h1122_3344_5566_7788, 1'b0);
        check("if_rdata_hold", if_rdata, 64'hDEAD_BEEF);

        // IF drops its request right after the grant edge
        access(1'b0, 1'b0, 8'h40, 64'h0, 64'h4040_4040_4040_4040, 1'b1);
        check("dm_rdata_hold", dm_rdata, 64'h1122_3344_5566_7788);

        // Reset while waiting on memory
        wait_idle();
        str_exp_q.push_back('{wr: 1'b0, addr: 8'h10, data: 64'h0});
        if_req = 1'b1; if_addr = 8'h10;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_rden", 64'(mem_rden), 64'(0));
        check("abort_ack", 64'(if_ack), 64'(0));
        repeat (6) @(negedge clk);
        access(1'b0, 1'b0, 8'h10, 64'h0, 64'hDEAD_BEEF, 1'b0);

        // Simultaneous held requests, starting from a fresh grant history
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_idle();
        c = cyc;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            bit dm_turn = (k % 2 == 0);
`else
            bit dm_turn = 1'b1;
`endif
            ack_exp_q.push_back('{is_dm: dm_turn,
                                  data: dm_turn ? 64'h1122_3344_5566_7788 : 64'hDEAD_BEEF,
                                  cyc: c + int'(LAT) + 2 + k * (int'(LAT) + 3)});
            str_exp_q.push_back('{wr: 1'b0, addr: dm_turn ? 8'h20 : 8'h10, data: 64'h0});
        end
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h20;
        if_req = 1'b1; if_addr = 8'h10;
        acks = 0;
        n = 0;
        while (acks < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (if_ack || dm_ack) acks++;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        check("conflict_acks", 64'(acks), 64'(4));

        // Latency sweep
        for (int i = 0; i < 3; i++) sweep_one(i, int'(SW_LAT[i]));

        repeat (4) @(negedge clk);
        check("pending_acks", 64'(ack_exp_q.size()), 64'(0));
        check("pending_strobes", 64'(str_exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
